hazard_ctrl: RTL and testbench

- Central pipeline hazard controller for the 5-stage core (F, D, E, M, W).
- Generates per-stage stall/flush for the pipeline registers: F->D in the decode stage, D->E, E->M and M->W.
- Selects ALU operand forwarding sources.
- Keeps a scoreboard of registers awaiting long-latency results (mul/div).
- Sequences the multi-cycle exception flush.
- Maintains saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central hazard controller for the 5-stage core (F, D, E, M, W).
//
// Purpose:
//   - Per-stage stall/flush control for the F->D, D->E, E->M and M->W
//     pipeline registers.
//   - ALU operand forwarding selection for the instruction in E.
//   - Scoreboard of registers waiting on long-latency (mul/div) results.
//   - Multi-cycle exception flush sequencing with a one-cycle trap redirect.
//   - Saturating performance counters for decode stalls and decode flushes.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   id_*                       decode-stage operands, destination, type
//   ex_*                       execute-stage operands, load flag, branch taken
//   mem_*                      memory-stage destination, dcache busy
//   wb_*                       writeback destination, exception flag
//   lat_done_in/_rd_in         long-latency unit completion and its rd
//   stall_{f,d,e,m}_out        hold the corresponding pipeline register
//   flush_{d,e,m}_out          load a bubble into F->D, D->E, E->M
//   fwd_{a,b}_out              00 regfile, 01 W result, 10 M result
//   xcpt_redirect_out          one-cycle PC redirect to the trap vector
//   stall_cnt_out/flush_cnt_out saturating cycle counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_BITS          = 5,
    parameter int NREGS             = 32,
    parameter int CNT_W             = 32,
    parameter int XCPT_FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid_in,
    input  logic [REG_BITS-1:0] id_rs1_in,
    input  logic [REG_BITS-1:0] id_rs2_in,
    input  logic                id_uses_rs1_in,
    input  logic                id_uses_rs2_in,
    input  logic [REG_BITS-1:0] id_rd_in,
    input  logic                id_reg_write_in,
    input  logic                id_long_lat_in,
    input  logic [REG_BITS-1:0] ex_rs1_in,
    input  logic [REG_BITS-1:0] ex_rs2_in,
    input  logic [REG_BITS-1:0] ex_rd_in,
    input  logic                ex_is_load_in,
    input  logic                ex_branch_taken_in,
    input  logic [REG_BITS-1:0] mem_rd_in,
    input  logic                mem_reg_write_in,
    input  logic                mem_busy_in,
    input  logic [REG_BITS-1:0] wb_rd_in,
    input  logic                wb_reg_write_in,
    input  logic                wb_xcpt_in,
    input  logic                lat_done_in,
    input  logic [REG_BITS-1:0] lat_done_rd_in,
    output logic                stall_f_out,
    output logic                stall_d_out,
    output logic                stall_e_out,
    output logic                stall_m_out,
    output logic                flush_d_out,
    output logic                flush_e_out,
    output logic                flush_m_out,
    output logic [1:0]          fwd_a_out,
    output logic [1:0]          fwd_b_out,
    output logic                xcpt_redirect_out,
    output logic [CNT_W-1:0]    stall_cnt_out,
    output logic [CNT_W-1:0]    flush_cnt_out
);

    // Flush-cycle counter needs at least one bit even when a single cycle is used.
    localparam int XC_W = (XCPT_FLUSH_CYCLES > 1) ? $clog2(XCPT_FLUSH_CYCLES) : 1;
    localparam logic [XC_W-1:0] XC_LAST = XC_W'(XCPT_FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_XFLUSH = 1'b1
    } state_t;

    state_t            state_reg;
    logic [XC_W-1:0]   xcnt_reg;
    logic              xcpt_redirect_reg;
    logic [NREGS-1:0]  busy_reg;
    logic [NREGS-1:0]  busy_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m;
    logic in_run;
    logic rs1_hazard, rs2_hazard, waw_hazard, d_hazard;
    logic xcpt_enter, sb_issue, sb_complete;

    assign in_run = (state_reg == ST_RUN);

    // A source only matters if the instruction reads it and it is not x0.
    assign rs1_hazard = id_uses_rs1_in && (id_rs1_in != '0) &&
                        ((ex_is_load_in && (ex_rd_in == id_rs1_in)) || busy_reg[id_rs1_in]);
    assign rs2_hazard = id_uses_rs2_in && (id_rs2_in != '0) &&
                        ((ex_is_load_in && (ex_rd_in == id_rs2_in)) || busy_reg[id_rs2_in]);
    assign waw_hazard = id_reg_write_in && (id_rd_in != '0) && busy_reg[id_rd_in];
    assign d_hazard   = rs1_hazard || rs2_hazard || waw_hazard;

    // Stall/flush priority: exception flush, dcache busy, taken branch, D hazard.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!in_run) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (mem_busy_in) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (ex_branch_taken_in) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (d_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign stall_f_out = stall_f;
    assign stall_d_out = stall_d;
    assign stall_e_out = stall_e;
    assign stall_m_out = stall_m;
    assign flush_d_out = flush_d;
    assign flush_e_out = flush_e;
    assign flush_m_out = flush_m;

    // Forwarding: the younger M result shadows the older W result.
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs);
        if (mem_reg_write_in && (mem_rd_in != '0) && (mem_rd_in == rs))
            return 2'b10;
        else if (wb_reg_write_in && (wb_rd_in != '0) && (wb_rd_in == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a_out = fwd_sel(ex_rs1_in);
    assign fwd_b_out = fwd_sel(ex_rs2_in);

    // Exception flush sequencer; redirect is registered so it is high in the
    // first XFLUSH cycle only.
    assign xcpt_enter = in_run && wb_xcpt_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_RUN;
            xcnt_reg          <= '0;
            xcpt_redirect_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    xcnt_reg <= '0;
                    if (wb_xcpt_in) begin
                        state_reg         <= ST_XFLUSH;
                        xcpt_redirect_reg <= 1'b1;
                    end else begin
                        xcpt_redirect_reg <= 1'b0;
                    end
                end
                ST_XFLUSH: begin
                    xcpt_redirect_reg <= 1'b0;
                    if (xcnt_reg == XC_LAST) begin
                        state_reg <= ST_RUN;
                        xcnt_reg  <= '0;
                    end else begin
                        xcnt_reg <= xcnt_reg + XC_W'(1);
                    end
                end
                default: begin
                    state_reg         <= ST_RUN;
                    xcnt_reg          <= '0;
                    xcpt_redirect_reg <= 1'b0;
                end
            endcase
        end
    end

    assign xcpt_redirect_out = xcpt_redirect_reg;

    // Scoreboard. Issue only when the instruction actually leaves decode.
    // Exception entry clears everything; a same-register issue beats a
    // completion; completions are ignored while flushing.
    assign sb_issue    = in_run && id_valid_in && id_reg_write_in && id_long_lat_in &&
                         (id_rd_in != '0) && !stall_d && !flush_d;
    assign sb_complete = in_run && lat_done_in;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
            assign busy_next[gi] =
                xcpt_enter                                             ? 1'b0 :
                (sb_issue && (id_rd_in == REG_BITS'(gi)))              ? 1'b1 :
                (sb_complete && (lat_done_rd_in == REG_BITS'(gi)))     ? 1'b0 :
                                                                         busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_d && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush_d && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt_out = stall_cnt_reg;
    assign flush_cnt_out = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model that keeps the scoreboard
// as a queue of busy register numbers and the flush sequence as a countdown.
// A narrow counter width is used so counter saturation is reached.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int RB   = 5;
    localparam int NR   = 32;
    localparam int CW   = 4;
    localparam int XF   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid_in, id_uses_rs1_in, id_uses_rs2_in, id_reg_write_in, id_long_lat_in;
    logic [RB-1:0] id_rs1_in, id_rs2_in, id_rd_in;
    logic [RB-1:0] ex_rs1_in, ex_rs2_in, ex_rd_in;
    logic          ex_is_load_in, ex_branch_taken_in;
    logic [RB-1:0] mem_rd_in;
    logic          mem_reg_write_in, mem_busy_in;
    logic [RB-1:0] wb_rd_in;
    logic          wb_reg_write_in, wb_xcpt_in;
    logic          lat_done_in;
    logic [RB-1:0] lat_done_rd_in;
    logic          stall_f_out, stall_d_out, stall_e_out, stall_m_out;
    logic          flush_d_out, flush_e_out, flush_m_out;
    logic [1:0]    fwd_a_out, fwd_b_out;
    logic          xcpt_redirect_out;
    logic [CW-1:0] stall_cnt_out, flush_cnt_out;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_BITS(RB), .NREGS(NR), .CNT_W(CW), .XCPT_FLUSH_CYCLES(XF)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid_in(id_valid_in), .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
        .id_uses_rs1_in(id_uses_rs1_in), .id_uses_rs2_in(id_uses_rs2_in),
        .id_rd_in(id_rd_in), .id_reg_write_in(id_reg_write_in), .id_long_lat_in(id_long_lat_in),
        .ex_rs1_in(ex_rs1_in), .ex_rs2_in(ex_rs2_in), .ex_rd_in(ex_rd_in),
        .ex_is_load_in(ex_is_load_in), .ex_branch_taken_in(ex_branch_taken_in),
        .mem_rd_in(mem_rd_in), .mem_reg_write_in(mem_reg_write_in), .mem_busy_in(mem_busy_in),
        .wb_rd_in(wb_rd_in), .wb_reg_write_in(wb_reg_write_in), .wb_xcpt_in(wb_xcpt_in),
        .lat_done_in(lat_done_in), .lat_done_rd_in(lat_done_rd_in),
        .stall_f_out(stall_f_out), .stall_d_out(stall_d_out),
        .stall_e_out(stall_e_out), .stall_m_out(stall_m_out),
        .flush_d_out(flush_d_out), .flush_e_out(flush_e_out), .flush_m_out(flush_m_out),
        .fwd_a_out(fwd_a_out), .fwd_b_out(fwd_b_out),
        .xcpt_redirect_out(xcpt_redirect_out),
        .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       busy_q[$];       // registers awaiting a long-latency result
    int       xf_left = 0;     // remaining exception-flush cycles, 0 = running
    bit       m_redirect = 0;
    int       m_scnt = 0;
    int       m_fcnt = 0;
    bit [3:0] e_st;            // {f,d,e,m}
    bit [2:0] e_fl;            // {d,e,m}

    function automatic bit is_busy(int r);
        foreach (busy_q[i]) if (busy_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [1:0] src_of(int r);
        if (mem_reg_write_in && mem_rd_in != 0 && int'(mem_rd_in) == r) return 2'd2;
        if (wb_reg_write_in && wb_rd_in != 0 && int'(wb_rd_in) == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit src_blocked(bit used, int r);
        if (!used || r == 0) return 1'b0;
        return (ex_is_load_in && int'(ex_rd_in) == r) || is_busy(r);
    endfunction

    task automatic model_eval();
        bit hz;
        e_st = '0;
        e_fl = '0;
        hz = src_blocked(id_uses_rs1_in, int'(id_rs1_in)) ||
             src_blocked(id_uses_rs2_in, int'(id_rs2_in)) ||
             (id_reg_write_in && id_rd_in != 0 && is_busy(int'(id_rd_in)));
        if (xf_left > 0)             e_fl = 3'b111;
        else if (mem_busy_in)        e_st = 4'b1111;
        else if (ex_branch_taken_in) e_fl = 3'b110;
        else if (hz) begin
            e_st = 4'b1100;
            e_fl = 3'b010;
        end
    endtask

    task automatic model_update();
        if (e_st[2] && m_scnt < MAXC) m_scnt++;
        if (e_fl[2] && m_fcnt < MAXC) m_fcnt++;
        if (xf_left > 0) begin
            xf_left--;
            m_redirect = 1'b0;
        end else if (wb_xcpt_in) begin
            xf_left    = XF;
            m_redirect = 1'b1;
            busy_q.delete();
        end else begin
            m_redirect = 1'b0;
            if (lat_done_in)
                foreach (busy_q[i]) if (busy_q[i] == int'(lat_done_rd_in)) begin
                    busy_q.delete(i);
                    break;
                end
            if (id_valid_in && id_reg_write_in && id_long_lat_in && id_rd_in != 0 &&
                !e_st[2] && !e_fl[2] && !is_busy(int'(id_rd_in)))
                busy_q.push_back(int'(id_rd_in));
        end
    endtask

    task automatic model_reset();
        busy_q.delete();
        xf_left    = 0;
        m_redirect = 1'b0;
        m_scnt     = 0;
        m_fcnt     = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clr_in();
        id_valid_in = 0; id_uses_rs1_in = 0; id_uses_rs2_in = 0; id_reg_write_in = 0;
        id_long_lat_in = 0; id_rs1_in = 0; id_rs2_in = 0; id_rd_in = 0;
        ex_rs1_in = 0; ex_rs2_in = 0; ex_rd_in = 0; ex_is_load_in = 0; ex_branch_taken_in = 0;
        mem_rd_in = 0; mem_reg_write_in = 0; mem_busy_in = 0;
        wb_rd_in = 0; wb_reg_write_in = 0; wb_xcpt_in = 0;
        lat_done_in = 0; lat_done_rd_in = 0;
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit ll);
        id_valid_in = v; id_rs1_in = RB'(rs1); id_uses_rs1_in = u1;
        id_rs2_in = RB'(rs2); id_uses_rs2_in = u2;
        id_rd_in = RB'(rd); id_reg_write_in = rw; id_long_lat_in = ll;
    endtask

    // Called with inputs applied just after a falling edge.
    task automatic settle_check();
        #1;
        model_eval();
        check_val("stall", {stall_f_out, stall_d_out, stall_e_out, stall_m_out}, e_st);
        check_val("flush", {flush_d_out, flush_e_out, flush_m_out}, e_fl);
        check_val("fwd_a", fwd_a_out, src_of(int'(ex_rs1_in)));
        check_val("fwd_b", fwd_b_out, src_of(int'(ex_rs2_in)));
        check_val("redirect", xcpt_redirect_out, m_redirect);
        check_val("stall_cnt", stall_cnt_out, m_scnt);
        check_val("flush_cnt", flush_cnt_out, m_fcnt);
        $display("cyc %0d: stall=%b flush=%b fwd=%0d/%0d redir=%0d scnt=%0d fcnt=%0d busy=%p",
                 cyc, {stall_f_out, stall_d_out, stall_e_out, stall_m_out},
                 {flush_d_out, flush_e_out, flush_m_out}, fwd_a_out, fwd_b_out,
                 xcpt_redirect_out, stall_cnt_out, flush_cnt_out, busy_q);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_inputs();
        clr_in();
        set_id($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        ex_rs1_in          = RB'($urandom_range(0, 7));
        ex_rs2_in          = RB'($urandom_range(0, 7));
        ex_rd_in           = RB'($urandom_range(0, 7));
        ex_is_load_in      = ($urandom_range(0, 3) == 0);
        ex_branch_taken_in = ($urandom_range(0, 7) == 0);
        mem_rd_in          = RB'($urandom_range(0, 7));
        mem_reg_write_in   = $urandom_range(0, 1);
        mem_busy_in        = ($urandom_range(0, 9) == 0);
        wb_rd_in           = RB'($urandom_range(0, 7));
        wb_reg_write_in    = $urandom_range(0, 1);
        wb_xcpt_in         = ($urandom_range(0, 39) == 0);
        lat_done_in        = ($urandom_range(0, 2) == 0);
        if (busy_q.size() > 0 && $urandom_range(0, 3) != 0)
            lat_done_rd_in = RB'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
        else
            lat_done_rd_in = RB'($urandom_range(0, 7));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clr_in();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        settle_check();                       // reset state
        reset = 1'b1;
        @(negedge clk);

        // Load-use: E = lw x5, D = add x6,x5,x1
        clr_in();
        ex_is_load_in = 1; ex_rd_in = 5;
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        settle_check();
        check_val("lu_bubble", {stall_f_out, stall_d_out, flush_e_out}, 3'b111);
        advance();
        clr_in();
        wb_rd_in = 5; wb_reg_write_in = 1; ex_rs1_in = 5; ex_rs2_in = 1;
        settle_check();
        check_val("lu_fwd_w", fwd_a_out, 2'b01);
        check_val("lu_scnt", stall_cnt_out, 1);
        advance();

        // Forward priority: M and W both write x3
        clr_in();
        mem_rd_in = 3; mem_reg_write_in = 1; wb_rd_in = 3; wb_reg_write_in = 1;
        ex_rs1_in = 3; ex_rs2_in = 0;
        settle_check();
        check_val("fwd_prio_a", fwd_a_out, 2'b10);
        check_val("fwd_prio_b", fwd_b_out, 2'b00);
        advance();

        // Scoreboard: mul x7, then add x8,x7 stalls until after lat_done(x7)
        clr_in(); set_id(1, 1, 1, 2, 1, 7, 1, 1);
        settle_check(); advance();
        for (int i = 0; i < 3; i++) begin
            clr_in(); set_id(1, 7, 1, 0, 0, 8, 1, 0);
            lat_done_in = (i == 2); lat_done_rd_in = 7;
            settle_check();
            check_val("sb_wait", stall_d_out, 1'b1);
            advance();
        end
        clr_in(); set_id(1, 7, 1, 0, 0, 8, 1, 0);
        settle_check();
        check_val("sb_release", stall_d_out, 1'b0);
        advance();
        // Completion and issue of x7 on the same edge: issue wins
        clr_in(); set_id(1, 1, 1, 2, 1, 7, 1, 1);
        lat_done_in = 1; lat_done_rd_in = 7;
        settle_check(); advance();
        clr_in(); set_id(1, 7, 1, 0, 0, 9, 1, 0);
        settle_check();
        check_val("sb_set_wins", stall_d_out, 1'b1);
        advance();
        clr_in(); lat_done_in = 1; lat_done_rd_in = 7;
        settle_check(); advance();

        // Taken branch beats load-use in the same cycle
        clr_in(); ex_is_load_in = 1; ex_rd_in = 5; ex_branch_taken_in = 1;
        set_id(1, 5, 1, 0, 0, 6, 1, 0);
        settle_check();
        check_val("br_over_hz", {flush_d_out, flush_e_out, stall_d_out}, 3'b110);
        advance();

        // dcache busy for 5 cycles during a taken branch
        for (int i = 0; i < 6; i++) begin
            clr_in(); ex_branch_taken_in = 1; mem_busy_in = (i < 5);
            settle_check();
            if (i < 5)
                check_val("busy_hold", {stall_f_out, stall_d_out, stall_e_out, stall_m_out,
                                        flush_d_out, flush_e_out, flush_m_out}, 7'b1111000);
            else
                check_val("busy_done", {stall_d_out, flush_d_out, flush_e_out}, 3'b011);
            advance();
        end

        // Exception with busy[4] set
        clr_in(); set_id(1, 0, 0, 0, 0, 4, 1, 1);
        settle_check(); advance();
        clr_in(); wb_xcpt_in = 1;
        settle_check(); advance();
        for (int i = 0; i < XF; i++) begin
            clr_in(); wb_xcpt_in = (i == 1);
            lat_done_in = 1; lat_done_rd_in = 4;
            settle_check();
            check_val("xf_redir", xcpt_redirect_out, (i == 0));
            check_val("xf_flush", {flush_d_out, flush_e_out, flush_m_out}, 3'b111);
            advance();
        end
        clr_in(); set_id(1, 4, 1, 0, 0, 10, 1, 0);
        settle_check();
        check_val("xf_sb_clear", {stall_d_out, flush_d_out}, 2'b00);
        advance();

        // Asynchronous reset in the middle of the flush
        clr_in(); wb_xcpt_in = 1;
        settle_check(); advance();
        clr_in();
        settle_check();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_val("arst_redir", xcpt_redirect_out, 1'b0);
        check_val("arst_flush", {flush_d_out, flush_e_out, flush_m_out}, 3'b000);
        check_val("arst_cnts", {stall_cnt_out, flush_cnt_out}, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc++;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            settle_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
